// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the parametrised synchronous FIFO family.
//   - DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   - clog2_plus1()         : width needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

   // Occupancy runs 0..depth inclusive, so one more code than depth entries.
   function automatic int clog2_plus1(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   WIDTH x DEPTH storage array: one synchronous write port, one
//   asynchronous (combinational) read port. Contents are never reset.
// Ports
//   clk      in   rising-edge clock
//   i_we     in   write strobe
//   i_waddr  in   write address (0..DEPTH-1)
//   i_wdata  in   write data
//   i_raddr  in   read address (0..DEPTH-1)
//   o_rdata  out  read data for i_raddr, same cycle
// ---------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds, sticky overflow / underflow,
//   synchronous flush and optional first-word-fall-through read mode.
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   flush         in   synchronous clear of contents and errors
//   write_en      in   write request
//   data_in       in   write data
//   read_en       in   read request (FWFT: pop the visible head)
//   data_out      out  read data (FWFT=0: registered; FWFT=1: head view)
//   full / empty  out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: a write was dropped
//   underflow     out  sticky: a read was attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          write_en,
   input  logic [WIDTH-1:0]              data_in,
   input  logic                          read_en,
   output logic [WIDTH-1:0]              data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [clog2_plus1(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = clog2_plus1(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_af;
   logic             r_ae;
   logic             r_ovf;
   logic             r_unf;

   logic             w_rd_ok;
   logic             w_wr_ok;
   logic [CW-1:0]    w_count_next;
   logic [WIDTH-1:0] w_head;

   // Explicit wrap compare so any DEPTH works, not just powers of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == C_LAST) ? '0 : p + 1'b1;
   endfunction

   // A write on a full FIFO is still accepted when a pop frees a slot
   // on the same edge.
   assign w_rd_ok = read_en & ~r_empty;
   assign w_wr_ok = write_en & (~r_full | w_rd_ok);

   always_comb begin
      w_count_next = r_count;
      if (w_wr_ok && !w_rd_ok) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_wr_ok && w_rd_ok) begin
         w_count_next = r_count - 1'b1;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_ok & ~flush),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Pointers, count, flags and sticky errors. Flags are registered from
   // the next count so they line up with the count output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_af     <= 1'b0;
         r_ae     <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_af     <= 1'b0;
         r_ae     <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == C_DEPTH);
         r_af    <= (w_count_next >= C_AF);
         r_ae    <= (w_count_next <= C_AE);
         if (write_en && !w_wr_ok) begin
            r_ovf <= 1'b1;
         end
         if (read_en && !w_rd_ok) begin
            r_unf <= 1'b1;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head of queue is always on the output; zero while empty.
         assign data_out = r_empty ? '0 : w_head;
      end else begin : g_std
         logic [WIDTH-1:0] r_dout;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_dout <= '0;
            end else if (flush) begin
               r_dout <= '0;
            end else if (w_rd_ok) begin
               r_dout <= w_head;
            end
         end
         assign data_out = r_dout;
      end
   endgenerate

   assign count        = r_count;
   assign empty        = r_empty;
   assign full         = r_full;
   assign almost_full  = r_af;
   assign almost_empty = r_ae;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule
